// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, rx FSM states and the parity check helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    DONE
  } rx_state_e;

  // ones_odd is the XOR of payload and received parity bit.
  function automatic logic parity_error(logic [1:0] mode, logic ones_odd);
    case (mode)
      PAR_EVEN: return ones_odd;
      PAR_ODD:  return ~ones_odd;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional oversampling tick: phase accumulator adds BAUD*OVS per clock, wraps at CLK_HZ.
module uart_baud_gen #(
  parameter int CLK_HZ = 3125000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 8
) (
  input  logic clk_3125,
  input  logic rst_n,
  output logic tick
);

  localparam logic [31:0] INC = 32'(BAUD * OVS);
  localparam logic [31:0] LIM = 32'(CLK_HZ);

  logic [31:0] acc;
  logic [31:0] acc_next;

  assign acc_next = acc + INC;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_next >= LIM) begin
      acc  <= acc_next - LIM;
      tick <= 1'b1;
    end else begin
      acc  <= acc_next;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit 3-sample majority vote, parity/framing/overrun
// reporting, one-entry valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int         CLK_HZ    = 3125000,
  parameter int         BAUD      = 115200,
  parameter int         OVS       = 8,
  parameter int         DATA_BITS = 8,
  parameter logic [1:0] PARITY    = 2'd0,
  parameter int         STOP_BITS = 1
) (
  input  logic                 clk_3125,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int              PH_W    = $clog2(OVS);
  localparam logic [PH_W-1:0] S0_PH   = PH_W'(OVS / 2 - 1);
  localparam logic [PH_W-1:0] S1_PH   = PH_W'(OVS / 2);
  localparam logic [PH_W-1:0] VOTE_PH = PH_W'(OVS / 2 + 1);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(OVS - 1);
  localparam bit              HAS_PAR = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);

  logic                 tick;
  logic [1:0]           sync;
  logic [1:0]           warm;
  logic                 rs;
  logic                 rs_prev;
  logic                 fall;
  rx_state_e            state;
  logic [PH_W-1:0]      ph;
  logic [3:0]           bit_cnt;
  logic [1:0]           smp;
  logic                 vote;
  logic [DATA_BITS-1:0] shreg;
  logic                 pbit;
  logic                 ferr;

  uart_baud_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) u_baud (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .tick     (tick)
  );

  // rs_prev is held at 0 until the sync chain carries real line data, so a line
  // already low at reset release is not mistaken for a falling edge.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      warm    <= 2'b00;
      rs_prev <= 1'b0;
    end else begin
      sync    <= {sync[0], rx};
      warm    <= {warm[0], 1'b1};
      rs_prev <= rs & warm[1];
    end
  end

  assign rs   = sync[1];
  assign fall = rs_prev & ~rs;
  assign vote = (smp[0] & smp[1]) | (smp[0] & rs) | (smp[1] & rs);

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ph            <= '0;
      bit_cnt       <= '0;
      smp           <= '0;
      shreg         <= '0;
      pbit          <= 1'b0;
      ferr          <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: if (fall) begin
          state   <= START;
          ph      <= '0;
          bit_cnt <= '0;
          ferr    <= 1'b0;
          rx_busy <= 1'b1;
        end

        // A consumer accepting in this very cycle frees the slot for the new frame.
        DONE: begin
          state <= IDLE;
          if (!rx_valid || rx_ready) begin
            rx_data       <= shreg;
            rx_parity_err <= parity_error(PARITY, ^{shreg, pbit});
            rx_frame_err  <= ferr;
            rx_valid      <= 1'b1;
          end else begin
            rx_overrun <= 1'b1;
          end
        end

        default: if (tick) begin
          ph <= (ph == LAST_PH) ? '0 : ph + 1'b1;
          if (ph == S0_PH) smp[0] <= rs;
          if (ph == S1_PH) smp[1] <= rs;

          case (state)
            START: begin
              if (ph == VOTE_PH && vote) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else if (ph == LAST_PH) begin
                state <= DATA;
              end
            end
            DATA: begin
              if (ph == VOTE_PH) shreg <= {vote, shreg[DATA_BITS-1:1]};
              if (ph == LAST_PH) begin
                if (bit_cnt == 4'(DATA_BITS - 1)) begin
                  bit_cnt <= '0;
                  state   <= HAS_PAR ? PAR : STOP;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end
            end
            PAR: begin
              if (ph == VOTE_PH) pbit <= vote;
              if (ph == LAST_PH) state <= STOP;
            end
            STOP: begin
              if (ph == VOTE_PH && !vote) ferr <= 1'b1;
              // A low first stop bit ends the frame early so a held-low break parks in IDLE.
              if (ph == VOTE_PH && !vote && bit_cnt == '0) begin
                state   <= DONE;
                rx_busy <= 1'b0;
              end else if (ph == LAST_PH) begin
                if (bit_cnt == 4'(STOP_BITS - 1)) begin
                  state   <= DONE;
                  rx_busy <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1, 8E1 and 7N2@9600 instances driven by a bit-timed line model.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam realtime CLK_NS  = 320.0;
  localparam realtime BT_FAST = 1.0e9 / 115200.0;
  localparam realtime BT_SLOW = 1.0e9 / 9600.0;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [2:0] rx_line  = 3'b111;
  logic [2:0] rx_ready = 3'b000;
  wire  [7:0] d0;
  wire  [7:0] d1;
  wire  [6:0] d2;
  wire  [2:0] valid, perr, ferr, ovr, busy;

  frame_t sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     ovr_cnt[3] = '{0, 0, 0};
  int     ovr_base;

  always #(CLK_NS / 2) clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
  end

  uart_rx_param u_8n1 (
    .clk_3125(clk), .rst_n(rst_n), .rx(rx_line[0]), .rx_data(d0), .rx_valid(valid[0]),
    .rx_ready(rx_ready[0]), .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]),
    .rx_overrun(ovr[0]), .rx_busy(busy[0])
  );

  uart_rx_param #(.PARITY(2'd1)) u_8e1 (
    .clk_3125(clk), .rst_n(rst_n), .rx(rx_line[1]), .rx_data(d1), .rx_valid(valid[1]),
    .rx_ready(rx_ready[1]), .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]),
    .rx_overrun(ovr[1]), .rx_busy(busy[1])
  );

  uart_rx_param #(.BAUD(9600), .DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .clk_3125(clk), .rst_n(rst_n), .rx(rx_line[2]), .rx_data(d2), .rx_valid(valid[2]),
    .rx_ready(rx_ready[2]), .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]),
    .rx_overrun(ovr[2]), .rx_busy(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] cur_data(input int s);
    case (s)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {2'b00, d2};
    endcase
  endfunction

  function automatic frame_t mk(input logic [8:0] data, input logic pe, input logic fe);
    frame_t f;
    f.data = data;
    f.perr = pe;
    f.ferr = fe;
    return f;
  endfunction

  // Drives one frame LSB-first, optionally flipping bit gbit for two clocks at mid-bit.
  task automatic send(input int s, input logic [8:0] data, input int nbits, input bit par,
                      input logic pbit, input logic [1:0] stop, input int nstop,
                      input int gbit, input realtime bt);
    rx_line[s] = 1'b0;
    #(bt);
    for (int i = 0; i < nbits; i++) begin
      rx_line[s] = data[i];
      if (i == gbit) begin
        #(bt / 2 - CLK_NS);
        rx_line[s] = ~data[i];
        #(2 * CLK_NS);
        rx_line[s] = data[i];
        #(bt / 2 - CLK_NS);
      end else begin
        #(bt);
      end
    end
    if (par) begin
      rx_line[s] = pbit;
      #(bt);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_line[s] = stop[i];
      #(bt);
    end
    rx_line[s] = 1'b1;
    #(bt);
  endtask

  task automatic wait_level(input int s, input logic lvl, input string tag);
    int n = 0;
    while (busy[s] !== lvl && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy[s], lvl);
  endtask

  // Pops the next expected frame, compares it, checks it holds, then consumes it.
  task automatic collect(input int s, input string tag);
    frame_t exp;
    int     n = 0;
    while (valid[s] !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, valid[s], 1'b1);
    check({tag, "_sb_pending"}, sb.size(), 1);
    if (valid[s] === 1'b1 && sb.size() != 0) begin
      exp = sb.pop_front();
      check({tag, "_data"}, cur_data(s), exp.data);
      check({tag, "_perr"}, perr[s], exp.perr);
      check({tag, "_ferr"}, ferr[s], exp.ferr);
      repeat (4) @(negedge clk);
      check({tag, "_hold_valid"}, valid[s], 1'b1);
      check({tag, "_hold_data"}, cur_data(s), exp.data);
      rx_ready[s] = 1'b1;
      @(negedge clk);
      rx_ready[s] = 1'b0;
      check({tag, "_cleared"}, valid[s], 1'b0);
      check({tag, "_idle"}, busy[s], 1'b0);
    end
  endtask

  initial begin
    #(15_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_valid", valid[0], 1'b0);
    check("rst_data", d0, 8'h00);
    check("rst_perr", perr[0], 1'b0);
    check("rst_ferr", ferr[0], 1'b0);
    check("rst_overrun", ovr[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    rst_n = 1'b1;
    #(BT_FAST * 2);

    // 8N1 0xA5, busy sampled in the middle of the frame
    sb.push_back(mk(9'h0A5, 1'b0, 1'b0));
    fork
      send(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1, -1, BT_FAST);
      begin
        #(BT_FAST * 4.5);
        check("a5_busy_mid", busy[0], 1'b1);
      end
    join
    collect(0, "a5");

    // Even parity: 0x07 has three ones, so a 0 parity bit is wrong and a 1 is right
    sb.push_back(mk(9'h007, 1'b1, 1'b0));
    send(1, 9'h007, 8, 1'b1, 1'b0, 2'b11, 1, -1, BT_FAST);
    collect(1, "par_bad");
    sb.push_back(mk(9'h007, 1'b0, 1'b0));
    send(1, 9'h007, 8, 1'b1, 1'b1, 2'b11, 1, -1, BT_FAST);
    collect(1, "par_ok");

    // Stop bit low
    sb.push_back(mk(9'h055, 1'b0, 1'b1));
    send(0, 9'h055, 8, 1'b0, 1'b0, 2'b00, 1, -1, BT_FAST);
    collect(0, "stop_low");

    // Break: one zero frame with framing error, then silence until a new edge
    rx_line[0] = 1'b0;
    #(BT_FAST * 30);
    check("break_busy", busy[0], 1'b0);
    check("break_valid", valid[0], 1'b1);
    rx_line[0] = 1'b1;
    sb.push_back(mk(9'h000, 1'b0, 1'b1));
    collect(0, "break");
    #(BT_FAST * 2);
    check("break_single", valid[0], 1'b0);
    sb.push_back(mk(9'h03C, 1'b0, 1'b0));
    send(0, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1, -1, BT_FAST);
    collect(0, "after_break");

    // Short low pulse on an idle line is a false start
    rx_line[0] = 1'b0;
    #(BT_FAST / 8);
    rx_line[0] = 1'b1;
    #(BT_FAST * 2);
    check("glitch_busy", busy[0], 1'b0);
    check("glitch_valid", valid[0], 1'b0);

    // Narrow inverted glitch inside data bit 2 is outvoted
    sb.push_back(mk(9'h0C3, 1'b0, 1'b0));
    send(0, 9'h0C3, 8, 1'b0, 1'b0, 2'b11, 1, 2, BT_FAST);
    collect(0, "glitch_data");

    // Overrun: second frame dropped while the first is still held
    ovr_base = ovr_cnt[0];
    send(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1, -1, BT_FAST);
    send(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1, -1, BT_FAST);
    check("ovr_pulses", ovr_cnt[0] - ovr_base, 1);
    check("ovr_kept_data", d0, 8'h11);
    sb.push_back(mk(9'h011, 1'b0, 1'b0));
    collect(0, "ovr_first");

    // Consumer accepts exactly on the DONE cycle of the second frame: no overrun
    ovr_base = ovr_cnt[0];
    send(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1, -1, BT_FAST);
    fork
      send(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1, -1, BT_FAST);
      begin
        wait_level(0, 1'b1, "accept_busy_rise");
        wait_level(0, 1'b0, "accept_busy_fall");
        rx_ready[0] = 1'b1;
        @(negedge clk);
        rx_ready[0] = 1'b0;
        check("accept_valid", valid[0], 1'b1);
        check("accept_data", d0, 8'h22);
      end
    join
    check("accept_no_ovr", ovr_cnt[0] - ovr_base, 0);
    sb.push_back(mk(9'h022, 1'b0, 1'b0));
    collect(0, "accept");

    // Reset mid-frame with a frame held: everything clears asynchronously
    send(0, 9'h066, 8, 1'b0, 1'b0, 2'b11, 1, -1, BT_FAST);
    check("pre_rst_valid", valid[0], 1'b1);
    fork
      send(0, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 1, -1, BT_FAST);
      begin
        #(BT_FAST * 4.3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", valid[0], 1'b0);
        check("mid_rst_data", d0, 8'h00);
        check("mid_rst_busy", busy[0], 1'b0);
      end
    join
    rx_line[0] = 1'b0;
    #(BT_FAST);
    rst_n = 1'b1;
    #(BT_FAST * 3);
    check("rst_low_line_busy", busy[0], 1'b0);
    check("rst_low_line_valid", valid[0], 1'b0);
    rx_line[0] = 1'b1;
    #(BT_FAST * 2);
    sb.push_back(mk(9'h096, 1'b0, 1'b0));
    send(0, 9'h096, 8, 1'b0, 1'b0, 2'b11, 1, -1, BT_FAST);
    collect(0, "post_rst");

    // 7N2 at 9600: 0xA5 truncates to 7'h25; second stop bit low is a framing error
    sb.push_back(mk(9'h025, 1'b0, 1'b0));
    send(2, 9'h0A5, 7, 1'b0, 1'b0, 2'b11, 2, -1, BT_SLOW);
    collect(2, "slow_a5");
    sb.push_back(mk(9'h01B, 1'b0, 1'b1));
    send(2, 9'h01B, 7, 1'b0, 1'b0, 2'b01, 2, -1, BT_SLOW);
    collect(2, "slow_stop2_low");

    check("sb_drained", sb.size(), 0);
    check("no_ovr_8e1", ovr_cnt[1], 0);
    check("no_ovr_7n2", ovr_cnt[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
